// File: rtl/pad_bus_dir_ctrl_if.sv
// pad_bus_dir_ctrl_if: requester and pad-ring signals
// of the half-duplex pad bus controller
interface pad_bus_dir_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             WR_VALID;
  logic [WIDTH-1:0] WR_DATA;
  logic             WR_READY;
  logic             RD_REQ;
  logic             RD_READY;
  logic             RD_VALID;
  logic [WIDTH-1:0] RD_DATA;
  logic [WIDTH-1:0] PAD_O;
  logic [WIDTH-1:0] PAD_NOE;
  logic [WIDTH-1:0] PAD_I;
  logic             BUSY;

  modport master (
    output WR_VALID, WR_DATA, RD_REQ, PAD_I,
    input  WR_READY, RD_READY, RD_VALID, RD_DATA,
    input  PAD_O, PAD_NOE, BUSY
  );

  modport slave (
    input  WR_VALID, WR_DATA, RD_REQ, PAD_I,
    output WR_READY, RD_READY, RD_VALID, RD_DATA,
    output PAD_O, PAD_NOE, BUSY
  );
endinterface

// File: rtl/pad_bus_dir_ctrl.sv
// pad_bus_dir_ctrl: half-duplex pad bus sequencer
// arbitrates write/read, inserts turnaround dead cycles
module pad_bus_dir_ctrl #(
  parameter int WIDTH         = 8,
  parameter int TURN_CYCLES   = 2,
  parameter int DRIVE_CYCLES  = 1,
  parameter int SAMPLE_CYCLES = 2,
  parameter int PARK_CYCLES   = 4
) (
  input logic               CLK,
  input logic               RESET,
  pad_bus_dir_ctrl_if.slave bus
);

  localparam int MAX_A =
    (TURN_CYCLES > DRIVE_CYCLES) ? TURN_CYCLES : DRIVE_CYCLES;
  localparam int MAX_B =
    (SAMPLE_CYCLES > PARK_CYCLES) ? SAMPLE_CYCLES : PARK_CYCLES;
  localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    S_RELEASED,
    S_TA_TX,
    S_DRIVE,
    S_DRV_IDLE,
    S_TA_RX,
    S_SAMPLE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_wr_q, last_wr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             pad_noe_q, pad_noe_d;
  logic [WIDTH-1:0] pad_o_q, pad_o_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             busy_q, busy_d;

  logic accept;
  logic wr_hs;
  logic rd_hs;
  logic capture;
  logic drive_next;

  // A phase of lim cycles ends in the cycle where cnt == lim-1;
  // lim == 0 ends on the first cycle.
  function automatic logic done(
    input logic [CW-1:0] c,
    input int            lim
  );
    return (int'(c) + 1) >= lim;
  endfunction

  // Grant: write wins unless a read contends and write went last.
  assign accept = !RESET &&
                  ((state_q == S_RELEASED) ||
                   (state_q == S_DRV_IDLE));
  assign wr_hs = accept && bus.WR_VALID &&
                 (!bus.RD_REQ || !last_wr_q);
  assign rd_hs = accept && bus.RD_REQ &&
                 (!bus.WR_VALID || last_wr_q);

  assign bus.WR_READY = wr_hs;
  assign bus.RD_READY = rd_hs;
  assign bus.PAD_NOE  = {WIDTH{pad_noe_q}};
  assign bus.PAD_O    = pad_o_q;
  assign bus.RD_DATA  = rd_data_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.BUSY     = busy_q;

  // State, phase counter, grant history and write data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_RELEASED;
      cnt_q     <= '0;
      last_wr_q <= 1'b0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_wr_q <= last_wr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next state: phase sequencing and handshake transitions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    last_wr_d = last_wr_q;
    wdata_d   = wdata_q;
    if (wr_hs) begin
      last_wr_d = 1'b1;
      wdata_d   = bus.WR_DATA;
    end
    if (rd_hs) begin
      last_wr_d = 1'b0;
    end
    unique case (state_q)
      S_RELEASED: begin
        if (wr_hs)      state_d = S_TA_TX;
        else if (rd_hs) state_d = S_SAMPLE;
      end
      S_TA_TX: begin
        if (done(cnt_q, TURN_CYCLES)) state_d = S_DRIVE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_DRIVE: begin
        if (done(cnt_q, DRIVE_CYCLES)) state_d = S_DRV_IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_DRV_IDLE: begin
        if (wr_hs)      state_d = S_DRIVE;
        else if (rd_hs) state_d = S_TA_RX;
        else if (done(cnt_q, PARK_CYCLES)) state_d = S_RELEASED;
        else cnt_d = cnt_q + CW'(1);
      end
      S_TA_RX: begin
        if (done(cnt_q, TURN_CYCLES)) state_d = S_SAMPLE;
        else cnt_d = cnt_q + CW'(1);
      end
      S_SAMPLE: begin
        if (done(cnt_q, SAMPLE_CYCLES)) state_d = S_RELEASED;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = S_RELEASED;
    endcase
  end

  // Outputs: pad drive follows the state being entered.
  always_comb begin
    capture    = (state_q == S_SAMPLE) &&
                 done(cnt_q, SAMPLE_CYCLES);
    drive_next = (state_d == S_DRIVE) ||
                 (state_d == S_DRV_IDLE);
    pad_noe_d  = !drive_next;
    pad_o_d    = drive_next ? wdata_d : '0;
    busy_d     = !((state_d == S_RELEASED) ||
                   (state_d == S_DRV_IDLE));
    rd_valid_d = capture;
    rd_data_d  = capture ? bus.PAD_I : rd_data_q;
  end

  // Registered pad and read-side outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pad_noe_q  <= 1'b1;
      pad_o_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pad_noe_q  <= pad_noe_d;
      pad_o_q    <= pad_o_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_pad_bus_dir_ctrl.sv
// tb_pad_bus_dir_ctrl: random and directed bench with a
// timeline model of the pad bus controller
module tb_pad_bus_dir_ctrl;
  localparam int W  = 8;
  localparam int T  = 2;
  localparam int D  = 1;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int L  = (P < 1) ? 1 : P;
  localparam int VW = 3 * W + 4;
  localparam int RW = 3 * W + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  pad_bus_dir_ctrl_if #(.WIDTH(W)) bus ();

  pad_bus_dir_ctrl #(
    .WIDTH(W),
    .TURN_CYCLES(T),
    .DRIVE_CYCLES(D),
    .SAMPLE_CYCLES(S),
    .PARK_CYCLES(P)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // timeline model: future cycles are scheduled on each grant
  int cyc;
  int idle_from;
  int cap_cyc;
  bit owner_wr;
  bit lg_wr;
  logic [W-1:0] last_wd;
  logic [W-1:0] exp_rdd;
  logic [W-1:0] cur_wd;
  logic [W-1:0] pi_hist [int];
  bit s_noe [int];
  bit s_busy [int];
  logic [W-1:0] s_o [int];
  bit cur_rst;
  bit e_wr;
  bit e_rd;
  logic [VW-1:0] exp_v;
  logic [VW-1:0] obs;
  logic [RW-1:0] rst_obs;
  logic [RW-1:0] rst_exp;

  assign obs = {bus.PAD_NOE, bus.PAD_O, bus.BUSY, bus.RD_VALID,
                bus.RD_DATA, bus.WR_READY, bus.RD_READY};
  assign rst_obs = {bus.PAD_NOE, bus.PAD_O, bus.RD_VALID,
                    bus.RD_DATA, bus.BUSY};
  assign rst_exp = {{W{1'b1}}, {W{1'b0}}, 1'b0,
                    {W{1'b0}}, 1'b0};

  task automatic sched(input int c, input bit noe,
                       input logic [W-1:0] o, input bit busy);
    s_noe[c]  = noe;
    s_o[c]    = o;
    s_busy[c] = busy;
  endtask

  task automatic apply(input bit wv, input logic [W-1:0] wd,
                       input bit rr, input logic [W-1:0] pi,
                       input bit r);
    bit drv;
    bit noe;
    bit busy;
    logic [W-1:0] o;
    cur_wd  = wd;
    cur_rst = r;
    rst = r;
    bus.WR_VALID = wv;
    bus.WR_DATA  = wd;
    bus.RD_REQ   = rr;
    bus.PAD_I    = pi;
    pi_hist[cyc] = pi;
    @(negedge clk);
    if (cyc >= idle_from) begin
      drv  = owner_wr && (cyc < idle_from + L);
      noe  = !drv;
      o    = drv ? last_wd : '0;
      busy = 1'b0;
    end else begin
      noe  = s_noe[cyc];
      o    = s_o[cyc];
      busy = s_busy[cyc];
    end
    if (cyc == cap_cyc) exp_rdd = pi_hist[cyc - 1];
    e_wr = !r && (cyc >= idle_from) && wv && (!rr || !lg_wr);
    e_rd = !r && (cyc >= idle_from) && rr && (!wv || lg_wr);
    exp_v = {{W{noe}}, o, busy, (cyc == cap_cyc), exp_rdd,
             e_wr, e_rd};
  endtask

  task automatic advance();
    int b;
    bit drv;
    if (cur_rst) begin
      idle_from = cyc + 1;
      owner_wr  = 1'b0;
      lg_wr     = 1'b0;
      cap_cyc   = -1;
      exp_rdd   = '0;
    end else if (e_wr || e_rd) begin
      drv = owner_wr && (cyc < idle_from + L);
      b = cyc + 1;
      if (e_wr) begin
        if (!drv) begin
          for (int k = 0; k < T; k++) sched(b + k, 1'b1, '0, 1'b1);
          b += T;
        end
        for (int k = 0; k < D; k++) sched(b + k, 1'b0, cur_wd, 1'b1);
        idle_from = b + D;
        owner_wr  = 1'b1;
        last_wd   = cur_wd;
        lg_wr     = 1'b1;
      end else begin
        if (drv) begin
          for (int k = 0; k < T; k++) sched(b + k, 1'b1, '0, 1'b1);
          b += T;
        end
        for (int k = 0; k < S; k++) sched(b + k, 1'b1, '0, 1'b1);
        b += S;
        cap_cyc   = b;
        idle_from = b;
        owner_wr  = 1'b0;
        lg_wr     = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.WR_VALID = 1'b0;
    bus.WR_DATA  = '0;
    bus.RD_REQ   = 1'b0;
    bus.PAD_I    = '0;
    repeat (3) @(posedge clk);
    #1;
    cyc = 0;
    idle_from = 0;
    owner_wr = 1'b0;
    lg_wr = 1'b0;
    cap_cyc = -1;
    exp_rdd = '0;
    last_wd = '0;
    for (int i = 0; i < 20; i++) begin
      apply(1'b0, '0, 1'b0, W'($urandom), 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_model cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      n_chk++;
      if ({bus.PAD_NOE, bus.PAD_O, bus.RD_DATA, bus.BUSY} !==
          {{W{1'b1}}, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d noe=%h o=%h rdd=%h busy=%b",
                 cyc, bus.PAD_NOE, bus.PAD_O, bus.RD_DATA, bus.BUSY);
      end
      advance();
    end
  endtask

  task automatic test_single_write();
    int e0;
    int k;
    bit dn;
    e0 = -1;
    for (int i = 0; i < 16; i++) begin
      apply(e0 < 0, 8'hA5, 1'b0, W'($urandom), 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL single_write_model cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      k = cyc - e0;
      if (e0 >= 0 && k <= 8) begin
        dn = (k >= 2) && (k <= 6);
        n_chk++;
        if ({bus.PAD_NOE, bus.PAD_O, bus.BUSY} !==
            {{W{!dn}}, (dn ? 8'hA5 : 8'h00), (k < 3)}) begin
          n_fail++;
          $display("FAIL single_write_e%0d noe=%h o=%h busy=%b exp_drive=%b",
                   k, bus.PAD_NOE, bus.PAD_O, bus.BUSY, dn);
        end
      end
      if (e_wr) e0 = cyc + 1;
      advance();
    end
    n_chk++;
    if (e0 < 0) begin
      n_fail++;
      $display("FAIL single_write_accept got=none exp=accept");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] dq [3];
    logic [W-1:0] eo;
    int idx;
    int e0;
    int k;
    dq[0] = 8'h11;
    dq[1] = 8'h22;
    dq[2] = 8'h33;
    idx = 0;
    e0 = -1;
    for (int i = 0; i < 30; i++) begin
      apply(idx < 3, (idx < 3) ? dq[idx] : '0, 1'b0,
            W'($urandom), 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL b2b_model cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      k = cyc - e0;
      if (e0 >= 0 && k <= 11) begin
        if (k < 2 || k == 11) eo = 8'h00;
        else if (k < 4)       eo = 8'h11;
        else if (k < 6)       eo = 8'h22;
        else                  eo = 8'h33;
        n_chk++;
        if ({bus.PAD_NOE, bus.PAD_O} !==
            {{W{(k < 2) || (k == 11)}}, eo}) begin
          n_fail++;
          $display("FAIL b2b_e%0d noe=%h o=%h exp_o=%h",
                   k, bus.PAD_NOE, bus.PAD_O, eo);
        end
      end
      if (e_wr) begin
        if (e0 < 0) e0 = cyc + 1;
        idx++;
      end
      advance();
    end
    n_chk++;
    if (idx != 3) begin
      n_fail++;
      $display("FAIL b2b_beats got=%0d exp=3", idx);
    end
  endtask

  task automatic test_write_read();
    bit wdone;
    int e0;
    int k;
    int pulses;
    wdone = 1'b0;
    e0 = -1;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      apply(!wdone, 8'h5A, wdone && (e0 < 0), 8'h3C, 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL wr_rd_model cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      k = cyc - e0;
      if (e0 >= 0) begin
        if (bus.RD_VALID === 1'b1) pulses++;
        if (k <= 3) begin
          n_chk++;
          if (bus.PAD_NOE !== {W{1'b1}}) begin
            n_fail++;
            $display("FAIL wr_rd_turn_e%0d noe=%h exp=ff",
                     k, bus.PAD_NOE);
          end
        end else if (k <= 8) begin
          n_chk++;
          if ({bus.RD_VALID, bus.RD_DATA} !== {(k == 4), 8'h3C}) begin
            n_fail++;
            $display("FAIL wr_rd_data_e%0d rdv=%b rdd=%h exp_rdv=%b exp_rdd=3c",
                     k, bus.RD_VALID, bus.RD_DATA, (k == 4));
          end
        end
      end
      if (e_wr) wdone = 1'b1;
      if (e_rd) e0 = cyc + 1;
      advance();
    end
    n_chk++;
    if (e0 < 0 || pulses != 1) begin
      n_fail++;
      $display("FAIL wr_rd_pulses got=%0d exp=1", pulses);
    end
  endtask

  task automatic test_contention();
    bit want_w;
    int grants;
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    advance();
    want_w = 1'b1;
    grants = 0;
    for (int i = 0; i < 60; i++) begin
      apply(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL contend_model cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      if (bus.WR_READY === 1'b1 || bus.RD_READY === 1'b1) begin
        n_chk++;
        if ({bus.WR_READY, bus.RD_READY} !== {want_w, !want_w}) begin
          n_fail++;
          $display("FAIL contend_order cyc=%0d got=%b%b exp=%b%b",
                   cyc, bus.WR_READY, bus.RD_READY, want_w, !want_w);
        end
        want_w = !want_w;
        grants++;
      end
      advance();
    end
    n_chk++;
    if (grants < 4) begin
      n_fail++;
      $display("FAIL contend_grants got=%0d exp>=4", grants);
    end
  endtask

  task automatic test_reset_mid();
    int ph;
    int ev;
    bit wv;
    bit rr;
    bit r;
    ph = 0;
    ev = 0;
    for (int i = 0; i < 150 && ph < 10; i++) begin
      wv = (ph == 1) || (ph == 8);
      rr = (ph == 3) || (ph == 5);
      r  = (ph == 0) ||
           (ph == 2 && cyc == ev + 2) ||
           (ph == 6 && cyc == ev + 1);
      apply(wv, 8'hC3, rr, 8'h77, r);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL rst_mid_model ph=%0d cyc=%0d got=%h exp=%h",
                 ph, cyc, obs, exp_v);
      end
      if ((ph == 3 || ph == 7) && cyc == ev) begin
        n_chk++;
        if (rst_obs !== rst_exp) begin
          n_fail++;
          $display("FAIL rst_mid_outputs ph=%0d got=%h exp=%h",
                   ph, rst_obs, rst_exp);
        end
      end
      if (ph == 7) begin
        n_chk++;
        if (bus.RD_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_no_rdv cyc=%0d got=%b exp=0",
                   cyc, bus.RD_VALID);
        end
      end
      if (ph == 4 && cyc == ev + S) begin
        n_chk++;
        if ({bus.RD_VALID, bus.RD_DATA} !== {1'b1, 8'h77}) begin
          n_fail++;
          $display("FAIL rst_mid_read got=%b/%h exp=1/77",
                   bus.RD_VALID, bus.RD_DATA);
        end
      end
      if (ph == 9) begin
        n_chk++;
        if (bus.PAD_NOE !== {W{(cyc - ev) < T}}) begin
          n_fail++;
          $display("FAIL rst_mid_turn k=%0d noe=%h", cyc - ev, bus.PAD_NOE);
        end
      end
      unique case (ph)
        0: ph = 1;
        1: if (e_wr) begin ev = cyc + 1; ph = 2; end
        2: if (r) begin ev = cyc + 1; ph = 3; end
        3: if (e_rd) begin ev = cyc + 1; ph = 4; end
        4: if (cyc == ev + S) ph = 5;
        5: if (e_rd) begin ev = cyc + 1; ph = 6; end
        6: if (r) begin ev = cyc + 1; ph = 7; end
        7: if (cyc == ev + S + 1) ph = 8;
        8: if (e_wr) begin ev = cyc + 1; ph = 9; end
        9: if (cyc == ev + T) ph = 10;
        default: ph = 10;
      endcase
      advance();
    end
    n_chk++;
    if (ph != 10) begin
      n_fail++;
      $display("FAIL rst_mid_timeout got_phase=%0d exp=10", ph);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      apply(($urandom % 3) == 0, W'($urandom),
            ($urandom % 4) == 0, W'($urandom),
            ($urandom % 97) == 0);
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 cyc, obs, exp_v);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_read();
    test_contention();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
